ovi_issue_arbiter: RTL and testbench

Arbitrates N_REQ scalar-side requesters for the single OVI vector issue channel. Owns the VPU issue-credit counter and scoreboard-ID (sb_id) allocation, and records which requester owns each in-flight sb_id. It routes VPU completions back to the owning requester. It sits between the requesters' issue ports and the OVI bridge's VPU issue/dispatch/completed buses.

---
 rtl/ovi_issue_arbiter.sv | 156 +++++++++++++++
 tb/tb_ovi_issue_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_issue_arbiter.sv
// Round-robin arbiter for the single OVI vector issue channel. It owns the VPU
// issue credits and sb_id allocation, and routes completions to their owners.
module ovi_issue_arbiter #(
  parameter int N_REQ   = 2,
  parameter int CREDITS = 4,
  parameter int SBID_W  = 5,
  parameter int VL_W    = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_REQ-1:0]      REQ_VALID,
  input  logic [N_REQ*32-1:0]   REQ_INSTR,
  input  logic [N_REQ*2-1:0]    REQ_SEW,
  input  logic [N_REQ*VL_W-1:0] REQ_VL,
  output logic [N_REQ-1:0]      REQ_GRANT,
  output logic [N_REQ-1:0]      REQ_DONE_VALID,
  output logic [63:0]           REQ_DONE_DATA,
  output logic                  ISSUE_VALID,
  output logic [31:0]           ISSUE_INSTR,
  output logic [1:0]            ISSUE_SEW,
  output logic [VL_W-1:0]       ISSUE_VL,
  output logic [SBID_W-1:0]     ISSUE_SBID,
  output logic                  DISPATCH_NEXT_SENIOR,
  input  logic                  ISSUE_CREDIT,
  input  logic                  COMPLETED_VALID,
  input  logic [SBID_W-1:0]     COMPLETED_SBID,
  input  logic [63:0]           COMPLETED_DEST_REG,
  output logic [3:0]            CREDITS_AVAIL,
  output logic                  ERR
);

  localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NSB   = 1 << SBID_W;
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [SBID_W-1:0] nxt_q;
  logic [OW-1:0]     rr_q;
  logic [NSB-1:0]    busy_q;
  logic [OW-1:0]     owner_q [NSB];
  logic              err_q;

  logic [31:0]       instr_a [N_REQ];
  logic [1:0]        sew_a   [N_REQ];
  logic [VL_W-1:0]   vl_a    [N_REQ];

  logic [OW-1:0]     cand;
  logic [OW-1:0]     win;
  logic              found;
  logic              can_issue;
  logic              grant_fire;
  logic              comp_hit;

  logic              issue_vld_p1;
  logic [31:0]       issue_instr_p1;
  logic [1:0]        issue_sew_p1;
  logic [VL_W-1:0]   issue_vl_p1;
  logic [SBID_W-1:0] issue_sbid_p1;
  logic [N_REQ-1:0]  done_vld_p1;
  logic [63:0]       done_data_p1;

  // Credit count presented on a 4-bit port; larger pools read as 15.
  function automatic logic [3:0] sat_cnt(input logic [CNT_W-1:0] c);
    if (32'(c) > 15) return 4'hF;
    return 4'(c);
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign instr_a[i] = REQ_INSTR[32*i +: 32];
    assign sew_a[i]   = REQ_SEW[2*i +: 2];
    assign vl_a[i]    = REQ_VL[VL_W*i +: VL_W];
  end

  // Stage p0: arbitration. A credit arriving this cycle already counts, and
  // the busy check sees the entry before any same-cycle completion clears it.
  always_comb begin
    cand      = '0;
    win       = '0;
    found     = 1'b0;
    REQ_GRANT = '0;
    can_issue = RST_N && ((cnt_q != '0) || ISSUE_CREDIT) && !busy_q[nxt_q];
    for (int k = 0; k < N_REQ; k++) begin
      cand = OW'((int'(rr_q) + k) % N_REQ);
      if (!found && REQ_VALID[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant_fire = can_issue && found;
    if (grant_fire) REQ_GRANT[win] = 1'b1;
    comp_hit = COMPLETED_VALID && busy_q[COMPLETED_SBID];
  end

  // Stage p1: issue/completion registers and arbiter bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q          <= CNT_W'(CREDITS);
      nxt_q          <= '0;
      rr_q           <= '0;
      busy_q         <= '0;
      err_q          <= 1'b0;
      issue_vld_p1   <= 1'b0;
      issue_instr_p1 <= '0;
      issue_sew_p1   <= '0;
      issue_vl_p1    <= '0;
      issue_sbid_p1  <= '0;
      done_vld_p1    <= '0;
      done_data_p1   <= '0;
    end else begin
      issue_vld_p1 <= grant_fire;
      if (grant_fire) begin
        issue_instr_p1  <= instr_a[win];
        issue_sew_p1    <= sew_a[win];
        issue_vl_p1     <= vl_a[win];
        issue_sbid_p1   <= nxt_q;
        nxt_q           <= nxt_q + 1'b1;
        rr_q            <= OW'((int'(win) + 1) % N_REQ);
        busy_q[nxt_q]   <= 1'b1;
      end

      unique case ({grant_fire, ISSUE_CREDIT})
        2'b10:   cnt_q <= cnt_q - 1'b1;
        2'b01: begin
          if (cnt_q != CNT_W'(CREDITS)) cnt_q <= cnt_q + 1'b1;
          else                          err_q <= 1'b1;
        end
        default: ;
      endcase

      done_vld_p1 <= '0;
      if (comp_hit) begin
        busy_q[COMPLETED_SBID]               <= 1'b0;
        done_vld_p1[owner_q[COMPLETED_SBID]] <= 1'b1;
        done_data_p1                         <= COMPLETED_DEST_REG;
      end else if (COMPLETED_VALID) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (grant_fire) owner_q[nxt_q] <= win;
  end

  assign ISSUE_VALID          = issue_vld_p1;
  assign ISSUE_INSTR          = issue_instr_p1;
  assign ISSUE_SEW            = issue_sew_p1;
  assign ISSUE_VL             = issue_vl_p1;
  assign ISSUE_SBID           = issue_sbid_p1;
  assign DISPATCH_NEXT_SENIOR = issue_vld_p1;
  assign REQ_DONE_VALID       = done_vld_p1;
  assign REQ_DONE_DATA        = done_data_p1;
  assign CREDITS_AVAIL        = sat_cnt(cnt_q);
  assign ERR                  = err_q;

endmodule

// File: tb/tb_ovi_issue_arbiter.sv
// Directed bench for ovi_issue_arbiter: a 4-credit instance plus a 32-credit
// instance (shared inputs) for the sb_id wrap-collision scenario.
module tb_ovi_issue_arbiter;

  localparam int N_REQ = 2;
  localparam int SBID_W = 5;
  localparam int VL_W = 15;

  logic                  CLK = 1'b0;
  logic                  RST_N;
  logic [N_REQ-1:0]      REQ_VALID;
  logic [N_REQ*32-1:0]   REQ_INSTR;
  logic [N_REQ*2-1:0]    REQ_SEW;
  logic [N_REQ*VL_W-1:0] REQ_VL;
  logic                  ISSUE_CREDIT;
  logic                  COMPLETED_VALID;
  logic [SBID_W-1:0]     COMPLETED_SBID;
  logic [63:0]           COMPLETED_DEST_REG;

  logic [N_REQ-1:0]  REQ_GRANT, REQ_DONE_VALID;
  logic [63:0]       REQ_DONE_DATA;
  logic              ISSUE_VALID, DISPATCH_NEXT_SENIOR, ERR;
  logic [31:0]       ISSUE_INSTR;
  logic [1:0]        ISSUE_SEW;
  logic [VL_W-1:0]   ISSUE_VL;
  logic [SBID_W-1:0] ISSUE_SBID;
  logic [3:0]        CREDITS_AVAIL;

  logic [N_REQ-1:0]  grant32, done_vld32;
  logic [63:0]       done_data32;
  logic              issue_valid32, dns32, err32;
  logic [31:0]       issue_instr32;
  logic [1:0]        issue_sew32;
  logic [VL_W-1:0]   issue_vl32;
  logic [SBID_W-1:0] issue_sbid32;
  logic [3:0]        credits32;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ovi_issue_arbiter #(.N_REQ(N_REQ), .CREDITS(4), .SBID_W(SBID_W), .VL_W(VL_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_INSTR(REQ_INSTR),
    .REQ_SEW(REQ_SEW), .REQ_VL(REQ_VL), .REQ_GRANT(REQ_GRANT),
    .REQ_DONE_VALID(REQ_DONE_VALID), .REQ_DONE_DATA(REQ_DONE_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR), .ISSUE_SEW(ISSUE_SEW),
    .ISSUE_VL(ISSUE_VL), .ISSUE_SBID(ISSUE_SBID),
    .DISPATCH_NEXT_SENIOR(DISPATCH_NEXT_SENIOR), .ISSUE_CREDIT(ISSUE_CREDIT),
    .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_SBID(COMPLETED_SBID),
    .COMPLETED_DEST_REG(COMPLETED_DEST_REG), .CREDITS_AVAIL(CREDITS_AVAIL), .ERR(ERR)
  );

  ovi_issue_arbiter #(.N_REQ(N_REQ), .CREDITS(32), .SBID_W(SBID_W), .VL_W(VL_W)) dut32 (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_INSTR(REQ_INSTR),
    .REQ_SEW(REQ_SEW), .REQ_VL(REQ_VL), .REQ_GRANT(grant32),
    .REQ_DONE_VALID(done_vld32), .REQ_DONE_DATA(done_data32),
    .ISSUE_VALID(issue_valid32), .ISSUE_INSTR(issue_instr32), .ISSUE_SEW(issue_sew32),
    .ISSUE_VL(issue_vl32), .ISSUE_SBID(issue_sbid32),
    .DISPATCH_NEXT_SENIOR(dns32), .ISSUE_CREDIT(ISSUE_CREDIT),
    .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_SBID(COMPLETED_SBID),
    .COMPLETED_DEST_REG(COMPLETED_DEST_REG), .CREDITS_AVAIL(credits32), .ERR(err32)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ_VALID = '0;
    ISSUE_CREDIT = 1'b0;
    COMPLETED_VALID = 1'b0;
    COMPLETED_SBID = '0;
    COMPLETED_DEST_REG = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    REQ_INSTR = {32'hB000_0001, 32'hA000_0000};
    REQ_SEW = {2'd2, 2'd1};
    REQ_VL = {15'd200, 15'd100};
    RST_N = 1'b0;
    REQ_VALID = 2'b11;
    step();
    step();
    checks++;
    if (REQ_GRANT !== 2'b00) begin
      errors++; $display("FAIL reset_grant: got %b want 00", REQ_GRANT);
    end
    checks++;
    if (ISSUE_VALID !== 1'b0 || ISSUE_SBID !== 5'd0 || ISSUE_INSTR !== 32'h0) begin
      errors++; $display("FAIL reset_issue: got v=%b sbid=%0d instr=%h want 0/0/0",
                         ISSUE_VALID, ISSUE_SBID, ISSUE_INSTR);
    end
    checks++;
    if (CREDITS_AVAIL !== 4'd4 || ERR !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b want 4/0", CREDITS_AVAIL, ERR);
    end
    checks++;
    if (REQ_DONE_VALID !== 2'b00 || REQ_DONE_DATA !== 64'h0) begin
      errors++; $display("FAIL reset_done: got %b/%h want 00/0", REQ_DONE_VALID, REQ_DONE_DATA);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_i;
    RST_N = 1'b1;
    REQ_VALID = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_i = (i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0001;
      #1;
      checks++;
      if (REQ_GRANT !== exp_g) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, REQ_GRANT, exp_g);
      end
      step();
      checks++;
      if (ISSUE_VALID !== 1'b1 || DISPATCH_NEXT_SENIOR !== 1'b1 || ISSUE_SBID !== 5'(i)
          || ISSUE_INSTR !== exp_i || CREDITS_AVAIL !== 4'(3 - i)) begin
        errors++; $display("FAIL rr_issue[%0d]: got v=%b dns=%b sbid=%0d instr=%h cnt=%0d want 1/1/%0d/%h/%0d",
                           i, ISSUE_VALID, DISPATCH_NEXT_SENIOR, ISSUE_SBID, ISSUE_INSTR,
                           CREDITS_AVAIL, i, exp_i, 3 - i);
      end
    end
    #1;
    checks++;
    if (REQ_GRANT !== 2'b00) begin
      errors++; $display("FAIL rr_no_credit_grant: got %b want 00", REQ_GRANT);
    end
    step();
    checks++;
    if (ISSUE_VALID !== 1'b0 || CREDITS_AVAIL !== 4'd0 || ISSUE_SEW !== 2'd2) begin
      errors++; $display("FAIL rr_stopped: got v=%b cnt=%0d sew=%0d want 0/0/2",
                         ISSUE_VALID, CREDITS_AVAIL, ISSUE_SEW);
    end
  endtask

  task automatic test_credit_bypass();
    REQ_VALID = 2'b10;
    #1;
    checks++;
    if (REQ_GRANT !== 2'b00) begin
      errors++; $display("FAIL bypass_wait: got %b want 00", REQ_GRANT);
    end
    ISSUE_CREDIT = 1'b1;
    #1;
    checks++;
    if (REQ_GRANT !== 2'b10) begin
      errors++; $display("FAIL bypass_grant: got %b want 10", REQ_GRANT);
    end
    step();
    idle_inputs();
    checks++;
    if (ISSUE_VALID !== 1'b1 || ISSUE_SBID !== 5'd4 || ISSUE_VL !== 15'd200
        || CREDITS_AVAIL !== 4'd0 || ERR !== 1'b0) begin
      errors++; $display("FAIL bypass_issue: got v=%b sbid=%0d vl=%0d cnt=%0d err=%b want 1/4/200/0/0",
                         ISSUE_VALID, ISSUE_SBID, ISSUE_VL, CREDITS_AVAIL, ERR);
    end
  endtask

  task automatic test_completion();
    do_reset();
    REQ_VALID = 2'b01;
    step();
    REQ_VALID = 2'b10;
    step();
    REQ_VALID = 2'b00;
    COMPLETED_VALID = 1'b1;
    COMPLETED_SBID = 5'd1;
    COMPLETED_DEST_REG = 64'hDEAD_BEEF;
    step();
    checks++;
    if (REQ_DONE_VALID !== 2'b10 || REQ_DONE_DATA !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL done_sb1: got %b/%h want 10/deadbeef", REQ_DONE_VALID, REQ_DONE_DATA);
    end
    COMPLETED_SBID = 5'd0;
    COMPLETED_DEST_REG = 64'h1234;
    step();
    checks++;
    if (REQ_DONE_VALID !== 2'b01 || REQ_DONE_DATA !== 64'h1234) begin
      errors++; $display("FAIL done_sb0: got %b/%h want 01/1234", REQ_DONE_VALID, REQ_DONE_DATA);
    end
    idle_inputs();
    step();
    checks++;
    if (REQ_DONE_VALID !== 2'b00 || ERR !== 1'b0 || CREDITS_AVAIL !== 4'd2) begin
      errors++; $display("FAIL done_after: got done=%b err=%b cnt=%0d want 00/0/2",
                         REQ_DONE_VALID, ERR, CREDITS_AVAIL);
    end
  endtask

  task automatic test_errors();
    COMPLETED_VALID = 1'b1;
    COMPLETED_SBID = 5'd7;
    COMPLETED_DEST_REG = 64'h55;
    step();
    idle_inputs();
    checks++;
    if (REQ_DONE_VALID !== 2'b00 || ERR !== 1'b1) begin
      errors++; $display("FAIL err_bad_sbid: got done=%b err=%b want 00/1", REQ_DONE_VALID, ERR);
    end
    do_reset();
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL err_cleared: got %b want 0", ERR);
    end
    ISSUE_CREDIT = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (CREDITS_AVAIL !== 4'd4 || ERR !== 1'b1) begin
      errors++; $display("FAIL err_overflow: got cnt=%0d err=%b want 4/1", CREDITS_AVAIL, ERR);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    REQ_VALID = 2'b01;
    ISSUE_CREDIT = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (issue_valid32 !== 1'b1 || issue_sbid32 !== 5'(i)) begin
        errors++; $display("FAIL wrap_issue[%0d]: got v=%b sbid=%0d want 1/%0d",
                           i, issue_valid32, issue_sbid32, i);
      end
    end
    ISSUE_CREDIT = 1'b0;
    #1;
    checks++;
    if (grant32 !== 2'b00) begin
      errors++; $display("FAIL wrap_stall: got %b want 00", grant32);
    end
    step();
    COMPLETED_VALID = 1'b1;
    COMPLETED_SBID = 5'd0;
    COMPLETED_DEST_REG = 64'h77;
    #1;
    checks++;
    if (grant32 !== 2'b00 || issue_valid32 !== 1'b0) begin
      errors++; $display("FAIL wrap_preclear: got g=%b v=%b want 00/0", grant32, issue_valid32);
    end
    step();
    COMPLETED_VALID = 1'b0;
    #1;
    checks++;
    if (grant32 !== 2'b01 || done_vld32 !== 2'b01 || done_data32 !== 64'h77) begin
      errors++; $display("FAIL wrap_unblock: got g=%b done=%b data=%h want 01/01/77",
                         grant32, done_vld32, done_data32);
    end
    step();
    idle_inputs();
    checks++;
    if (issue_valid32 !== 1'b1 || issue_sbid32 !== 5'd0 || err32 !== 1'b0) begin
      errors++; $display("FAIL wrap_reissue: got v=%b sbid=%0d err=%b want 1/0/0",
                         issue_valid32, issue_sbid32, err32);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    REQ_VALID = 2'b11;
    step();
    step();
    step();
    REQ_VALID = 2'b00;
    checks++;
    if (CREDITS_AVAIL !== 4'd1 || ISSUE_SBID !== 5'd2) begin
      errors++; $display("FAIL mid_before: got cnt=%0d sbid=%0d want 1/2", CREDITS_AVAIL, ISSUE_SBID);
    end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    checks++;
    if (CREDITS_AVAIL !== 4'd4 || ISSUE_VALID !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got cnt=%0d v=%b err=%b want 4/0/0",
                         CREDITS_AVAIL, ISSUE_VALID, ERR);
    end
    REQ_VALID = 2'b01;
    step();
    REQ_VALID = 2'b00;
    checks++;
    if (ISSUE_VALID !== 1'b1 || ISSUE_SBID !== 5'd0) begin
      errors++; $display("FAIL mid_first_sbid: got v=%b sbid=%0d want 1/0", ISSUE_VALID, ISSUE_SBID);
    end
    COMPLETED_VALID = 1'b1;
    COMPLETED_SBID = 5'd2;
    COMPLETED_DEST_REG = 64'h99;
    step();
    idle_inputs();
    checks++;
    if (REQ_DONE_VALID !== 2'b00 || ERR !== 1'b1) begin
      errors++; $display("FAIL mid_late_completion: got done=%b err=%b want 00/1", REQ_DONE_VALID, ERR);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    REQ_INSTR = '0;
    REQ_SEW = '0;
    REQ_VL = '0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_credit_bypass();
    test_completion();
    test_errors();
    test_wrap();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
